// File: rtl/ram_sync_bank.sv
// Synchronous single-port RAM bank: valid/ready requests, byte enables, registered response.
// Optional macro RAM_CLEAR_EN adds a post-reset sweep that zeroes every word before accepting requests.
module ram_sync_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   rsp_rdata
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic [IdxW-1:0]       idx;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] merged_word;

  logic                  rsp_valid_q;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  // A request presented while rst is high is never accepted.
  assign accept   = req_valid && req_ready && !rst;
  assign in_range = {1'b0, req_addr} < DepthExt;
  assign idx      = req_addr[IdxW-1:0];

`ifdef RAM_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        if (clr_cnt_q == LastAddr) begin
          state_d   = StReady;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end
      StReady: state_d = StReady;
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    clr_we    = 1'b0;
    unique case (state_q)
      StClear: clr_we    = 1'b1;
      StReady: req_ready = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end
`else
  assign req_ready = 1'b1;
`endif

  // Write-first: the response of a write carries the merged post-write word.
  always_comb begin
    cur_word    = mem[idx];
    merged_word = cur_word;
    for (int i = 0; i < NumBytes; i++) begin
      if (req_be[i]) begin
        merged_word[8*i +: 8] = req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef RAM_CLEAR_EN
      if (clr_we) begin
        mem[clr_cnt_q[IdxW-1:0]] <= '0;
      end
`endif
      if (accept && req_we && in_range) begin
        for (int i = 0; i < NumBytes; i++) begin
          if (req_be[i]) begin
            mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rsp_err_d = !in_range;
    if (!in_range) begin
      rsp_rdata_d = '0;
    end else if (req_we) begin
      rsp_rdata_d = merged_word;
    end else begin
      rsp_rdata_d = cur_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_err_q   <= rsp_err_d;
        rsp_rdata_q <= rsp_rdata_d;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ram_sync_bank.sv
// Self-checking bench for ram_sync_bank (DEPTH=12 so out-of-range addresses exist).
// Builds with or without RAM_CLEAR_EN; expectations adapt to the macro.
module tb_ram_sync_bank;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 12;
`ifdef RAM_CLEAR_EN
  localparam bit ClrEn = 1'b1;
`else
  localparam bit ClrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [3:0]    req_be = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] model [2**AW];
  logic [DW-1:0] exp_rdata;
  logic          exp_err;

  ram_sync_bank #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_be   (req_be),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  // Drive one accepted request, update the model, land #1 after the accepting edge.
  task automatic send(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wd;
    if (int'(addr) >= DEPTH) begin
      exp_err   = 1'b1;
      exp_rdata = '0;
    end else begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) model[addr][8*i +: 8] = wd[8*i +: 8];
        end
      end
      exp_err   = 1'b0;
      exp_rdata = model[addr];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int a = 0; a < 2**AW; a++) model[a] = '0;
  endtask

  // Count cycles until req_ready rises; req_valid stays as the caller left it, so any response
  // seen here is a stray one.
  task automatic wait_ready(output int n, output int stray);
    n = 0;
    stray = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b0) stray++;
      n++;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n, stray;
    rst = 1'b1;
    send(1'b1, 4'hF, 4'd2, 32'hCAFE_0001);
    #0;
    compared++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got v=%b e=%b d=%h, want v=0 e=0 d=0",
               rsp_valid, rsp_err, rsp_rdata);
    end
    compared++;
    if (req_ready !== !ClrEn) begin
      mismatched++;
      $display("FAIL reset_ready: got %b, want %b", req_ready, !ClrEn);
    end
    rst = 1'b0;
    req_we = 1'b0;
    wait_ready(n, stray);
    compared++;
    if (n != (ClrEn ? DEPTH : 0)) begin
      mismatched++;
      $display("FAIL clear_ready_delay: got %0d cycles, want %0d", n, ClrEn ? DEPTH : 0);
    end
    compared++;
    if (stray != 0) begin
      mismatched++;
      $display("FAIL clear_no_response: got %0d responses, want 0", stray);
    end
    clear_model();
  endtask

  // With clearing, read every word (all zero); without it, initialise every word.
  task automatic test_init();
    for (int a = 0; a < DEPTH; a++) begin
      send(!ClrEn, 4'hF, AW'(a), $urandom);
      compared++;
      if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_rdata !== exp_rdata) begin
        mismatched++;
        $display("FAIL init_addr%0d: got v=%b e=%b d=%h, want v=1 e=%b d=%h",
                 a, rsp_valid, rsp_err, rsp_rdata, exp_err, exp_rdata);
      end
    end
    idle();
  endtask

  task automatic test_basic();
    send(1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL basic_write: got v=%b e=%b d=%h, want v=1 e=0 d=deadbeef",
               rsp_valid, rsp_err, rsp_rdata);
    end
    send(1'b0, 4'h0, 4'd3, 32'h0);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL basic_read: got v=%b e=%b d=%h, want v=1 e=0 d=deadbeef",
               rsp_valid, rsp_err, rsp_rdata);
    end
    idle();
    compared++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_hold: got v=%b e=%b d=%h, want v=0 e=0 d=deadbeef",
               rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_byte_enable();
    send(1'b1, 4'hF, 4'd5, 32'h1122_3344);
    send(1'b1, 4'b0101, 4'd5, 32'hAABB_CCDD);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11BB_33DD) begin
      mismatched++;
      $display("FAIL be_merge_write: got v=%b d=%h, want v=1 d=11bb33dd", rsp_valid, rsp_rdata);
    end
    send(1'b1, 4'b0000, 4'd5, 32'hFFFF_FFFF);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11BB_33DD) begin
      mismatched++;
      $display("FAIL be_zero_write: got v=%b d=%h, want v=1 d=11bb33dd", rsp_valid, rsp_rdata);
    end
    send(1'b0, 4'hF, 4'd5, 32'h0);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11BB_33DD) begin
      mismatched++;
      $display("FAIL be_merge_read: got v=%b d=%h, want v=1 d=11bb33dd", rsp_valid, rsp_rdata);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    logic [AW-1:0] addrs [5];
    logic          wes   [5];
    addrs = '{4'd13, 4'd13, 4'd12, 4'd15, 4'd11};
    wes   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      send(wes[k], 4'hF, addrs[k], $urandom);
      compared++;
      if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_rdata !== exp_rdata) begin
        mismatched++;
        $display("FAIL oor_addr%0d: got v=%b e=%b d=%h, want v=1 e=%b d=%h",
                 addrs[k], rsp_valid, rsp_err, rsp_rdata, exp_err, exp_rdata);
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      send(1'b0, 4'h0, AW'(a), 32'h0);
      compared++;
      if (rsp_err !== 1'b0 || rsp_rdata !== exp_rdata) begin
        mismatched++;
        $display("FAIL oor_untouched%0d: got e=%b d=%h, want e=0 d=%h",
                 a, rsp_err, rsp_rdata, exp_rdata);
      end
    end
    idle();
  endtask

  task automatic test_streaming();
    logic [DW-1:0] wd;
    for (int k = 0; k < 8; k++) begin
      wd = $urandom;
      send(k % 2 == 0, 4'hF, 4'd7, wd);
      compared++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== exp_rdata) begin
        mismatched++;
        $display("FAIL stream_%0d: got v=%b e=%b d=%h, want v=1 e=0 d=%h",
                 k, rsp_valid, rsp_err, rsp_rdata, exp_rdata);
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        compared++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
          mismatched++;
          $display("FAIL rand_idle%0d: got v=%b e=%b d=%h, want v=0 e=%b d=%h",
                   k, rsp_valid, rsp_err, rsp_rdata, exp_err, exp_rdata);
        end
      end else begin
        send(1'($urandom), 4'($urandom), AW'($urandom_range(0, 15)), $urandom);
        compared++;
        if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_rdata !== exp_rdata) begin
          mismatched++;
          $display("FAIL rand_op%0d: got v=%b e=%b d=%h, want v=1 e=%b d=%h",
                   k, rsp_valid, rsp_err, rsp_rdata, exp_err, exp_rdata);
        end
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int n, stray;
    logic [DW-1:0] saved;
    send(1'b1, 4'hF, 4'd4, 32'h5A5A_0404);
    saved = model[4];
    // Read in flight, then rst with another read and a write presented.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd4;
    rst = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_drop: got v=%b, want v=0", rsp_valid);
    end
    req_we = 1'b1; req_be = 4'hF; req_wdata = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    wait_ready(n, stray);
    compared++;
    if (n != (ClrEn ? DEPTH : 0)) begin
      mismatched++;
      $display("FAIL reset_mid_delay: got %0d cycles, want %0d", n, ClrEn ? DEPTH : 0);
    end
    if (ClrEn) clear_model();
    send(1'b0, 4'h0, 4'd4, 32'h0);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== (ClrEn ? '0 : saved)) begin
      mismatched++;
      $display("FAIL reset_preserve: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_rdata, ClrEn ? '0 : saved);
    end
    idle();
  endtask

  task automatic test_restart();
    int n, stray;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    compared++;
    if (req_ready !== !ClrEn) begin
      mismatched++;
      $display("FAIL sweep_mid_ready: got %b, want %b", req_ready, !ClrEn);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready(n, stray);
    compared++;
    if (n != (ClrEn ? DEPTH : 0)) begin
      mismatched++;
      $display("FAIL sweep_restart_delay: got %0d cycles, want %0d", n, ClrEn ? DEPTH : 0);
    end
    if (ClrEn) clear_model();
    for (int a = 0; a < DEPTH; a++) begin
      send(1'b0, 4'h0, AW'(a), 32'h0);
      compared++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata) begin
        mismatched++;
        $display("FAIL restart_read%0d: got v=%b d=%h, want v=1 d=%h",
                 a, rsp_valid, rsp_rdata, exp_rdata);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_byte_enable();
    test_out_of_range();
    test_streaming();
    test_random();
    test_reset_mid();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
